project_blastn_dispatch_unit: RTL and testbench
===============================================

# project_blastn_dispatch_unit

Parametrised multi-lane successor to the single-job BLASTN control unit. It accepts job descriptors over the xcel request/response interface and queues them in a job FIFO. It dispatches each job to the next free ungapped-extension lane using a round-robin arbiter, and counts completions so software can poll. It sits between the processor's xcel port and `NUM_LANES` sequence-reader/extension pipelines.

## Interface
- `NUM_LANES`, default 4: number of downstream extension lanes (1..16).
- `JOB_DEPTH`, default 8: job FIFO entries (power of two, ≥2).
- `DESC_W`, default 256: descriptor width; 8 fields of 32 bits.
- `clk` in, 1: clock.
- `reset` in, 1: one clock; reset is asynchronous and active-low.
- `xcel_reqstream_msg/val/rdy` in/in/out, `xcel_req_t`/1/1: config request stream.
- `xcel_respstream_msg/val/rdy` out/out/in, `xcel_resp_t`/1/1: config response stream; msg is all-zero whenever val=0.
- `ostream_val` out, NUM_LANES: per-lane descriptor valid.
- `ostream_rdy` in, NUM_LANES: per-lane descriptor accept.
- `ostream_msg` out, NUM_LANES*DESC_W: lane i occupies bits [i*DESC_W +: DESC_W]; a lane's slice is zero whenever its val=0.
- `done` in, NUM_LANES: single-cycle per-lane job-complete pulse.
- `lane_busy` out, NUM_LANES: lane state ≠ IDLE.
- `jobs_done` out, 32: completion counter.

## Operation
- **Input buffer.** Requests pass through a 1-entry pipe input buffer. A request is dequeued and answered in the same cycle, when it is serviceable and `xcel_respstream_rdy`=1. The response echoes the `opaque` field of the request.
- **Register map, writes.** Write responses have type WRITE and data 0.
  - addr 1..8: staging field k, placed at descriptor bits [32*(k-1) +: 32]. Field order: query_seq, db_seq, q_pos, db_pos, score_addr, len_addr, q_pos_addr, db_pos_addr. Staging registers keep their values after a push.
  - addr 0: push the staging descriptor into the job FIFO. When FIFO count == JOB_DEPTH the request is not serviceable: no dequeue and no response until space frees.
  - addr 11: clear `jobs_done`.
  - Other addresses: no effect, normal response.
- **Register map, reads.** Read responses have type READ.
  - addr 0: returns 1 if the FIFO is empty and all lanes are IDLE, else 0.
  - addr 9: returns the FIFO count.
  - addr 10: returns `jobs_done`.
  - addr 12: returns `lane_busy`, zero-extended.
  - Other addresses: return 0.
- **Per-lane FSM.**
  - IDLE → SEND when the lane is granted. The FIFO head is captured into the lane's message register and the FIFO pops in that cycle.
  - SEND: `ostream_val`=1; on `ostream_rdy` → BUSY.
  - BUSY: on `done` → IDLE, and `jobs_done` increments.
  - `done` is ignored while the lane is in IDLE or SEND.
- **Arbiter.**
  - At most one grant per cycle, and only when the FIFO is non-empty.
  - Search starts at `rr_ptr`. The first IDLE lane at or after `rr_ptr`, wrapping modulo NUM_LANES, wins.
  - After a grant to lane g, `rr_ptr` = (g+1) mod NUM_LANES.
- **Counter.** `jobs_done` adds popcount(done & BUSY lanes) per cycle and wraps at 2^32. A clear in the same cycle as completions loads the completion count of that cycle, not 0.
- **Simultaneous push and pop.** Count is unchanged, and the push is still refused if count was full at the start of the cycle.

## Timing
- **Reset (`reset`=0, async).**
  - All lanes IDLE; FIFO empty; `rr_ptr`=0; staging=0; `jobs_done`=0.
  - Input buffer empty; `xcel_reqstream_rdy`=0 while reset is asserted.
  - All `ostream_val`=0, all msgs=0, `lane_busy`=0, `xcel_respstream_val`=0.
- **Reset mid-operation.** In-flight jobs and queued jobs are discarded; no response is issued for a buffered request.
- **Push-to-dispatch latency.**
  - Push serviced in cycle t; FIFO written at edge t.
  - Earliest grant in cycle t+1; `ostream_val` high in cycle t+2.
  - No FIFO bypass.
- **Descriptor hold.** A lane in SEND holds val and msg stable until rdy.
- **Lane reuse.** A lane in BUSY that receives `done` in cycle t is IDLE at t+1 and may be granted in t+1.
- **Throughput.** One push per cycle and one dispatch per cycle, sustained.

## Test plan
- **Single job.** NUM_LANES=4. Write fields 1..8 = 0x11..0x88, push, hold `ostream_rdy[0]`=1 → lane 0 val high 2 cycles after push with msg = {0x88,…,0x11}. Pulse `done[0]` → read addr 0 = 1, addr 10 = 1.
- **Round-robin.** Push 6 jobs with all rdy=1 and no done → lanes 0,1,2,3 granted on consecutive cycles; addr 9 reads 2. Pulse `done[2]` → 5th job goes to lane 2; pulse `done[0]` → 6th to lane 0.
- **FIFO full stall.** JOB_DEPTH=8, all lanes held BUSY, push 9 times → 9th push gets no response and `xcel_reqstream_rdy` stays low. Pulse `done[1]` → that lane takes the head, and the 9th response arrives on the following cycle.
- **Backpressure.** `ostream_rdy[0]`=0 for 5 cycles → val and msg stay constant; `done[0]` pulses during SEND are not counted (`jobs_done` unchanged).
- **Counter clear race.** Write addr 11 in the same cycle that `done[0]` and `done[3]` pulse on BUSY lanes → `jobs_done`=2.
- **Async reset mid-run.** Deassert `reset` to 0 with 3 lanes busy and 2 jobs queued → all outputs 0 immediately. After release: addr 0 reads 1, addr 9 reads 0.

Source files
------------

// File: rtl/project_blastn_dispatch_unit_pkg.sv
// Message formats for the xcel config request and response streams.
package project_blastn_dispatch_unit_pkg;

  localparam logic XCEL_READ  = 1'b0;
  localparam logic XCEL_WRITE = 1'b1;

  typedef struct packed {
    logic [7:0]  opaque;
    logic        msg_type;
    logic [4:0]  addr;
    logic [31:0] data;
  } xcel_req_t;

  typedef struct packed {
    logic [7:0]  opaque;
    logic        msg_type;
    logic [31:0] data;
  } xcel_resp_t;

endpackage

// File: rtl/project_blastn_dispatch_unit_if.sv
// xcel request/response stream bundle; the dispatcher is the slave side.
interface project_blastn_dispatch_unit_if;
  import project_blastn_dispatch_unit_pkg::*;

  xcel_req_t  xcel_reqstream_msg;
  logic       xcel_reqstream_val;
  logic       xcel_reqstream_rdy;
  xcel_resp_t xcel_respstream_msg;
  logic       xcel_respstream_val;
  logic       xcel_respstream_rdy;

  modport slave (
    input  xcel_reqstream_msg, xcel_reqstream_val, xcel_respstream_rdy,
    output xcel_reqstream_rdy, xcel_respstream_msg, xcel_respstream_val
  );

  modport master (
    output xcel_reqstream_msg, xcel_reqstream_val, xcel_respstream_rdy,
    input  xcel_reqstream_rdy, xcel_respstream_msg, xcel_respstream_val
  );
endinterface

// File: rtl/project_blastn_dispatch_unit.sv
// BLASTN job dispatcher: xcel register file, job FIFO, round-robin lane arbiter, completion counter.
// Push to lane valid is two cycles (no bypass); a push to a full FIFO waits in the input buffer.
module project_blastn_dispatch_unit
  import project_blastn_dispatch_unit_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int JOB_DEPTH = 8,
  parameter int DESC_W    = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  project_blastn_dispatch_unit_if.slave xcel,
  output logic [NUM_LANES-1:0]          ostream_val,
  input  logic [NUM_LANES-1:0]          ostream_rdy,
  output logic [NUM_LANES*DESC_W-1:0]   ostream_msg,
  input  logic [NUM_LANES-1:0]          done,
  output logic [NUM_LANES-1:0]          lane_busy,
  output logic [31:0]                   jobs_done
);
  localparam int PTR_W  = $clog2(JOB_DEPTH);
  localparam int CNT_W  = $clog2(JOB_DEPTH + 1);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int NFIELD = DESC_W / 32;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_BUSY} lane_state_t;

  xcel_req_t         r_req;
  logic              r_req_full;
  logic [DESC_W-1:0] r_staging;
  logic [DESC_W-1:0] r_fifo [JOB_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [LANE_W-1:0] r_rr_ptr;
  lane_state_t       r_state [NUM_LANES];
  lane_state_t       w_state_nxt [NUM_LANES];
  logic [DESC_W-1:0] r_msg [NUM_LANES];
  logic [31:0]       r_jobs_done;

  logic              w_is_push;
  logic              w_fifo_full;
  logic              w_resp_val;
  logic              w_deq;
  logic              w_enq;
  logic              w_write;
  logic              w_push;
  logic              w_clear;
  logic              w_grant;
  logic [LANE_W-1:0] w_grant_idx;
  logic [31:0]       w_rdata;
  logic [31:0]       w_done_cnt;
  xcel_resp_t        w_resp;

  // A full FIFO blocks only the push; every other request is always serviceable.
  assign w_is_push   = (r_req.msg_type == XCEL_WRITE) && (r_req.addr == 5'd0);
  assign w_fifo_full = (r_count == CNT_W'(JOB_DEPTH));
  assign w_resp_val  = r_req_full && !(w_is_push && w_fifo_full);
  assign w_deq       = w_resp_val && xcel.xcel_respstream_rdy;
  assign w_enq       = xcel.xcel_reqstream_val && xcel.xcel_reqstream_rdy;
  assign w_write     = w_deq && (r_req.msg_type == XCEL_WRITE);
  assign w_push      = w_write && (r_req.addr == 5'd0);
  assign w_clear     = w_write && (r_req.addr == 5'd11);

  assign xcel.xcel_reqstream_rdy  = reset && (!r_req_full || w_deq);
  assign xcel.xcel_respstream_val = w_resp_val;
  assign xcel.xcel_respstream_msg = w_resp;
  assign jobs_done                = r_jobs_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_full <= 1'b0;
      r_req      <= '0;
    end else if (w_enq) begin
      r_req_full <= 1'b1;
      r_req      <= xcel.xcel_reqstream_msg;
    end else if (w_deq) begin
      r_req_full <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (r_req.addr)
      5'd0:    w_rdata = {31'd0, (r_count == '0) && (lane_busy == '0)};
      5'd9:    w_rdata = 32'(r_count);
      5'd10:   w_rdata = r_jobs_done;
      5'd12:   w_rdata = 32'(lane_busy);
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    w_resp = '0;
    if (w_resp_val) begin
      w_resp.opaque   = r_req.opaque;
      w_resp.msg_type = r_req.msg_type;
      w_resp.data     = (r_req.msg_type == XCEL_WRITE) ? 32'd0 : w_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_staging <= '0;
    end else if (w_write && (r_req.addr >= 5'd1) && (r_req.addr <= 5'(NFIELD))) begin
      r_staging[32*(int'(r_req.addr)-1) +: 32] <= r_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= r_staging;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_grant) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_grant) r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_grant) r_count <= r_count - CNT_W'(1);
    end
  end

  // First IDLE lane at or after rr_ptr, wrapping; the FIFO head goes to it this cycle.
  always_comb begin
    int c;
    c           = 0;
    w_grant     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      c = int'(r_rr_ptr) + k;
      if (c >= NUM_LANES) c = c - NUM_LANES;
      if (!w_grant && (r_count != '0) && (r_state[LANE_W'(c)] == S_IDLE)) begin
        w_grant     = 1'b1;
        w_grant_idx = LANE_W'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_grant_idx == LANE_W'(NUM_LANES-1)) ? '0 : w_grant_idx + LANE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_state[i] <= S_IDLE;
        r_msg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_grant && (w_grant_idx == LANE_W'(i))) r_msg[i] <= r_fifo[r_rd_ptr];
      end
    end
  end

  // done only counts for lanes in BUSY; pulses during IDLE/SEND are dropped.
  always_comb begin
    w_done_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        S_IDLE: if (w_grant && (w_grant_idx == LANE_W'(i))) w_state_nxt[i] = S_SEND;
        S_SEND: if (ostream_rdy[i]) w_state_nxt[i] = S_BUSY;
        S_BUSY: if (done[i]) begin
          w_state_nxt[i] = S_IDLE;
          w_done_cnt     = w_done_cnt + 32'd1;
        end
        default: w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ostream_val = '0;
    lane_busy   = '0;
    ostream_msg = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      ostream_val[i] = (r_state[i] == S_SEND);
      lane_busy[i]   = (r_state[i] != S_IDLE);
      if (r_state[i] == S_SEND) ostream_msg[i*DESC_W +: DESC_W] = r_msg[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_jobs_done <= '0;
    end else if (w_clear) begin
      r_jobs_done <= w_done_cnt;
    end else begin
      r_jobs_done <= r_jobs_done + w_done_cnt;
    end
  end

endmodule

// File: tb/tb_project_blastn_dispatch_unit.sv
// Directed bench for the dispatcher: single job, round-robin order, FIFO-full stall, backpressure, clear race, async reset.
module tb_project_blastn_dispatch_unit;
  import project_blastn_dispatch_unit_pkg::*;

  localparam int NL = 4;
  localparam int JD = 8;
  localparam int DW = 256;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NL-1:0]    ostream_val;
  logic [NL-1:0]    ostream_rdy;
  logic [NL*DW-1:0] ostream_msg;
  logic [NL-1:0]    done;
  logic [NL-1:0]    lane_busy;
  logic [31:0]      jobs_done;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] tag      = 8'd0;

  project_blastn_dispatch_unit_if xif ();

  project_blastn_dispatch_unit #(.NUM_LANES(NL), .JOB_DEPTH(JD), .DESC_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .xcel        (xif),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg),
    .done        (done),
    .lane_busy   (lane_busy),
    .jobs_done   (jobs_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [1023:0] obs, input logic [1023:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; one request, one response.
  task automatic xcel(input logic wr, input logic [4:0] a, input logic [31:0] d, output logic [31:0] rdata);
    int k;
    xif.xcel_reqstream_msg  = '{opaque: tag, msg_type: wr, addr: a, data: d};
    xif.xcel_reqstream_val  = 1'b1;
    xif.xcel_respstream_rdy = 1'b1;
    #1;
    k = 0;
    while (!xif.xcel_reqstream_rdy && k < 100) begin step(); #1; k++; end
    check("req_rdy_wait", xif.xcel_reqstream_rdy, 1);
    step();
    xif.xcel_reqstream_val = 1'b0;
    xif.xcel_reqstream_msg = '0;
    #1;
    k = 0;
    while (!xif.xcel_respstream_val && k < 100) begin step(); #1; k++; end
    check("resp_val_wait", xif.xcel_respstream_val, 1);
    check("resp_opaque", xif.xcel_respstream_msg.opaque, tag);
    check("resp_type", xif.xcel_respstream_msg.msg_type, wr);
    rdata = xif.xcel_respstream_msg.data;
    step();
    tag++;
  endtask

  initial begin
    logic [31:0]      rd;
    logic [1023:0]    exp_all;
    logic [3:0]       exp_val;

    xif.xcel_reqstream_val  = 1'b0;
    xif.xcel_reqstream_msg  = '0;
    xif.xcel_respstream_rdy = 1'b0;
    ostream_rdy = '0;
    done        = '0;

    #12;
    check("rst_req_rdy", xif.xcel_reqstream_rdy, 0);
    check("rst_resp_val", xif.xcel_respstream_val, 0);
    check("rst_ostream_val", ostream_val, 0);
    check("rst_ostream_msg", ostream_msg, 0);
    check("rst_lane_busy", lane_busy, 0);
    check("rst_jobs_done", jobs_done, 0);
    step();
    reset = 1'b1;
    step();
    check("idle_resp_msg_zero", xif.xcel_respstream_msg, 0);

    // Single job through lane 0.
    ostream_rdy = 4'b0001;
    for (int k = 1; k <= 8; k++) xcel(1'b1, 5'(k), 32'(17 * k), rd);
    xcel(1'b1, 5'd0, 32'd0, rd);
    check("t1_no_bypass", ostream_val, 4'b0000);
    step();
    check("t1_val", ostream_val, 4'b0001);
    check("t1_msg", ostream_msg,
          256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011);
    step();
    done = 4'b0001;
    step();
    done = 4'b0000;
    check("t1_jobs_done_port", jobs_done, 1);
    xcel(1'b0, 5'd0, 32'd0, rd);  check("t1_rd_idle", rd, 1);
    xcel(1'b0, 5'd10, 32'd0, rd); check("t1_rd_jobs_done", rd, 1);
    xcel(1'b0, 5'd12, 32'd0, rd); check("t1_rd_lane_busy", rd, 0);
    xcel(1'b1, 5'd13, 32'd5, rd); check("t1_wr_unmapped", rd, 0);
    xcel(1'b0, 5'd13, 32'd0, rd); check("t1_rd_unmapped", rd, 0);

    // Reset pulse so round-robin starts at lane 0 with cleared staging.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Round-robin: six jobs, lanes 0..3 then two queued.
    ostream_rdy = 4'b1111;
    for (int j = 1; j <= 6; j++) begin
      xcel(1'b1, 5'd1, 32'(j), rd);
      xcel(1'b1, 5'd0, 32'd0, rd);
      step();
      exp_val = (j <= 4) ? 4'(1 << (j - 1)) : 4'b0000;
      exp_all = '0;
      if (j <= 4) exp_all[256*(j-1) +: 32] = 32'(j);
      check("t2_rr_val", ostream_val, exp_val);
      check("t2_rr_msg", ostream_msg, exp_all);
    end
    xcel(1'b0, 5'd9, 32'd0, rd);  check("t2_rd_count", rd, 2);
    xcel(1'b0, 5'd12, 32'd0, rd); check("t2_rd_busy", rd, 32'hF);
    done = 4'b0100;
    step();
    done = 4'b0000;
    step();
    exp_all = '0; exp_all[512 +: 32] = 32'd5;
    check("t2_job5_val", ostream_val, 4'b0100);
    check("t2_job5_msg", ostream_msg, exp_all);
    done = 4'b0001;
    step();
    done = 4'b0000;
    step();
    exp_all = '0; exp_all[0 +: 32] = 32'd6;
    check("t2_job6_val", ostream_val, 4'b0001);
    check("t2_job6_msg", ostream_msg, exp_all);
    step();
    xcel(1'b0, 5'd10, 32'd0, rd); check("t2_rd_jobs_done", rd, 2);
    xcel(1'b0, 5'd9, 32'd0, rd);  check("t2_rd_count_empty", rd, 0);

    // FIFO full: eight pushes fill it, the ninth stalls.
    for (int j = 1; j <= 8; j++) begin
      xcel(1'b1, 5'd1, 32'h100 + 32'(j), rd);
      xcel(1'b1, 5'd0, 32'd0, rd);
    end
    xcel(1'b0, 5'd9, 32'd0, rd); check("t3_rd_full", rd, 8);
    xif.xcel_reqstream_msg = '{opaque: tag, msg_type: 1'b1, addr: 5'd0, data: 32'd0};
    xif.xcel_reqstream_val = 1'b1;
    #1;
    check("t3_buf_accept", xif.xcel_reqstream_rdy, 1);
    step();
    xif.xcel_reqstream_val = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t3_stall_resp", xif.xcel_respstream_val, 0);
      check("t3_stall_rdy", xif.xcel_reqstream_rdy, 0);
      step();
    end
    done = 4'b0010;
    #1;
    check("t3_stall_resp_d", xif.xcel_respstream_val, 0);
    step();
    done = 4'b0000;
    #1;
    check("t3_grant_cycle_resp", xif.xcel_respstream_val, 0);
    step();
    #1;
    exp_all = '0; exp_all[256 +: 32] = 32'h101;
    check("t3_resp_after_pop", xif.xcel_respstream_val, 1);
    check("t3_resp_opaque", xif.xcel_respstream_msg.opaque, tag);
    check("t3_resp_data", xif.xcel_respstream_msg.data, 0);
    check("t3_lane1_val", ostream_val, 4'b0010);
    check("t3_lane1_msg", ostream_msg, exp_all);
    step();
    tag++;
    check("t3_jobs_done", jobs_done, 3);
    xcel(1'b0, 5'd9, 32'd0, rd); check("t3_rd_refilled", rd, 8);

    // Backpressure on lane 0; done pulses during SEND are ignored.
    ostream_rdy = 4'b1110;
    done = 4'b0001;
    step();
    done = 4'b0000;
    step();
    exp_all = '0; exp_all[0 +: 32] = 32'h102;
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_val", ostream_val, 4'b0001);
      check("t4_hold_msg", ostream_msg, exp_all);
      done = (c == 1 || c == 3) ? 4'b0001 : 4'b0000;
      step();
    end
    done = 4'b0000;
    check("t4_jobs_done", jobs_done, 4);
    ostream_rdy = 4'b1111;
    step();
    check("t4_accepted", ostream_val, 4'b0000);

    // Clear lands in the same cycle as two completions.
    xif.xcel_reqstream_msg = '{opaque: tag, msg_type: 1'b1, addr: 5'd11, data: 32'd0};
    xif.xcel_reqstream_val = 1'b1;
    #1;
    check("t5_buf_accept", xif.xcel_reqstream_rdy, 1);
    step();
    xif.xcel_reqstream_val = 1'b0;
    done = 4'b1001;
    #1;
    check("t5_clear_resp", xif.xcel_respstream_val, 1);
    step();
    done = 4'b0000;
    tag++;
    check("t5_jobs_done", jobs_done, 2);
    step();
    check("t5_wrap_lane3", ostream_val, 4'b1000);
    step();
    check("t5_wrap_lane0", ostream_val, 4'b0001);
    step();

    // Async reset with jobs in flight, queued, and a buffered request.
    xcel(1'b0, 5'd9, 32'd0, rd); check("t6_rd_queued", rd, 5);
    check("t6_busy_before", lane_busy, 4'b1111);
    xif.xcel_respstream_rdy = 1'b0;
    xif.xcel_reqstream_msg = '{opaque: tag, msg_type: 1'b0, addr: 5'd9, data: 32'd0};
    xif.xcel_reqstream_val = 1'b1;
    step();
    xif.xcel_reqstream_val = 1'b0;
    #1;
    check("t6_pending_resp", xif.xcel_respstream_val, 1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_val", ostream_val, 0);
    check("t6_rst_msg", ostream_msg, 0);
    check("t6_rst_busy", lane_busy, 0);
    check("t6_rst_jobs_done", jobs_done, 0);
    check("t6_rst_resp_val", xif.xcel_respstream_val, 0);
    check("t6_rst_req_rdy", xif.xcel_reqstream_rdy, 0);
    step();
    step();
    reset = 1'b1;
    xif.xcel_respstream_rdy = 1'b1;
    step();
    check("t6_no_stale_resp", xif.xcel_respstream_val, 0);
    xcel(1'b0, 5'd0, 32'd0, rd);  check("t6_rd_idle", rd, 1);
    xcel(1'b0, 5'd9, 32'd0, rd);  check("t6_rd_count", rd, 0);
    xcel(1'b0, 5'd10, 32'd0, rd); check("t6_rd_jobs_done", rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
